pfb_sync_arm_gen: RTL and testbench
===================================

// Module: pfb_sync_arm_gen
// PURPOSE
//  Consumes the 32-bit software control word from the mux_sel_pfb_sync OPB register (user_data_out, user_clk domain).
//  Arms on a software edge, then aligns to a selected sync source. Emits single-cycle PFB sync pulses, then free-runs
//  periodic pulses so the PFB/FFT frame stays aligned. Sits between the control register and the PFB sync input.
// PARAMETERS
//  SYNC_PERIOD  65536  cycles between periodic sync pulses in RUN; legal range 2..2^24
//  CNT_W        24     width of the period down-counter; must hold SYNC_PERIOD-1
// PORTS
//  user_clk       in   1   fabric/DSP clock; all logic is synchronous to its rising edge
//  user_rst_n     in   1   asynchronous active-low reset
//  ctrl_reg       in   32  control word from the register: [0] arm, [1] force, [3:2] src_sel, [31:4] ignored
//  ext_sync_in    in   1   ADC/external sync, synchronous to user_clk; rising edge is the event
//  pfb_sync_out   out  1   sync pulse to the PFB, 1 cycle wide, registered
//  armed          out  1   high while the state is ARMED
//  running        out  1   high while the state is RUN
//  sync_count     out  32  number of pulses emitted (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, user_rst_n=0) clears:
//   - state <= IDLE; pfb_sync_out, armed, running, sync_count <= 0
//   - period counter <= 0; edge-detect history regs (arm_q, force_q, ext_q) <= 0
//  Edge detection:
//   - arm_rise = ctrl_reg[0] & ~arm_q; force_rise and ext_rise are formed the same way
//   - history regs update every cycle
//   - A level held high produces no further events
//  Source select (src_sel = ctrl_reg[3:2], sampled in ARMED):
//   - 0: the event is ext_rise
//   - 1: the event fires immediately (internal)
//   - 2 and 3: software only; the event never fires and only force emits a pulse
//  State machine:
//   - IDLE:
//     - arm_rise -> ARMED
//   - ARMED:
//     - selected event -> pulse; counter <= SYNC_PERIOD-1; -> RUN
//     - arm_rise -> stay in ARMED
//   - RUN:
//     - counter==0 -> pulse; counter <= SYNC_PERIOD-1
//     - otherwise counter decrements
//     - ext_rise is ignored
//     - arm_rise -> ARMED; the counter holds
//  Force:
//   - force_rise in any state -> pulse
//   - In RUN, force also reloads the counter to SYNC_PERIOD-1
//   - No state change unless arm_rise occurs in the same cycle
//  Latency:
//   - ctrl_reg / ext_sync_in rising at cycle N -> edge seen at N -> pfb_sync_out high at N+1
//   - In RUN, pulses are exactly SYNC_PERIOD cycles apart
//  Simultaneous events:
//   - Never more than one pulse per cycle
//   - force_rise + arm_rise in IDLE or RUN -> one pulse, next state ARMED
//   - force_rise + the ARMED event -> one pulse, -> RUN
//   - force_rise + counter==0 -> one pulse, counter reload
//  Other rules:
//   - armed and running are registered decodes of the next state: they change in the same cycle as the state register
//   - The counter does not wrap; it always reloads from 0
//   - Reset mid-RUN aborts immediately; after release, the block needs a fresh arm_rise
//     (arm_q is 0, so an arm bit held high re-arms 1 cycle after reset release)
// CONFIGURATION
//  PFB_SYNC_CNT_EN defined:
//   - sync_count increments (mod 2^32, wraps) on every emitted pulse, in the same cycle pfb_sync_out is high
//   - sync_count clears to 0 on arm_rise; a clear and a pulse in the same cycle give sync_count=1
//  PFB_SYNC_CNT_EN undefined:
//   - sync_count is tied to 32'h0 and no counter logic is built
// TESTING (bench: SYNC_PERIOD=16, PFB_SYNC_CNT_EN defined unless stated)
//  1. Reset then ext_sync_in pulses with ctrl_reg=0
//     -> pfb_sync_out never asserts; armed=running=0; sync_count=0
//  2. ctrl_reg=0x1 (src 0) at cycle 5, ext_sync_in rises at cycle 20
//     -> armed=1 from cycle 6; pulse at 21; pulses at 37, 53; running=1
//  3. ctrl_reg=0x5 (src 1, arm) at cycle 5
//     -> ARMED at 6, pulse at 7; then pulses every 16 cycles; sync_count=3 after the 3rd pulse
//  4. In IDLE, ctrl_reg 0x0->0x2 (force) -> single pulse 1 cycle later; state stays IDLE
//     - In RUN, force at counter==5 -> pulse, next periodic pulse 16 cycles after the forced one
//  5. ctrl_reg 0x0->0x3 (arm+force same cycle) -> exactly one pulse; armed=1; sync_count=1
//  6. user_rst_n low mid-RUN -> all outputs 0 asynchronously
//     - Rebuild without PFB_SYNC_CNT_EN: scenario 3 gives sync_count=0 throughout

Source files
------------

// File: rtl/pfb_sync_arm_gen_if.sv
// Control/sync bundle between the OPB control register, the sync source and the PFB sync input.
interface pfb_sync_arm_gen_if;
    logic [31:0] ctrl_reg;
    logic        ext_sync_in;
    logic        pfb_sync_out;
    logic        armed;
    logic        running;
    logic [31:0] sync_count;

    modport master (
        output ctrl_reg, ext_sync_in,
        input  pfb_sync_out, armed, running, sync_count
    );

    modport slave (
        input  ctrl_reg, ext_sync_in,
        output pfb_sync_out, armed, running, sync_count
    );
endinterface

// File: rtl/pfb_sync_arm_gen.sv
// PFB sync generator: arm on a software edge, align to a selected source, then free-run periodic pulses.
// Optional pulse counter on sync_count is built only when PFB_SYNC_CNT_EN is defined.
module pfb_sync_arm_gen #(
    parameter int SYNC_PERIOD = 65536,
    parameter int CNT_W       = 24
) (
    input  logic                user_clk,
    input  logic                user_rst_n,
    pfb_sync_arm_gen_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SYNC_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arm_q, force_q, ext_q;
    logic             pulse_q, pulse_d;
    logic             armed_q, running_q;
    logic             arm_rise, force_rise, ext_rise, sel_event;
    logic             unused_ctrl;

    assign unused_ctrl = ^bus.ctrl_reg[31:4];

    assign arm_rise   = bus.ctrl_reg[0] & ~arm_q;
    assign force_rise = bus.ctrl_reg[1] & ~force_q;
    assign ext_rise   = bus.ext_sync_in & ~ext_q;

    always_comb begin
        sel_event = 1'b0;
        case (bus.ctrl_reg[3:2])
            2'd0:    sel_event = ext_rise;
            2'd1:    sel_event = 1'b1;
            default: sel_event = 1'b0;
        endcase
    end

    // Force always emits (at most one pulse per cycle); re-arm takes priority over alignment and the period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = force_rise;
        case (state_q)
            IDLE: begin
                if (arm_rise) state_d = ARMED;
            end
            ARMED: begin
                if (!arm_rise && sel_event) begin
                    pulse_d = 1'b1;
                    cnt_d   = RELOAD;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (arm_rise) begin
                    state_d = ARMED;
                end else if (force_rise || cnt_q == '0) begin
                    pulse_d = 1'b1;
                    cnt_d   = RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
            armed_q   <= 1'b0;
            running_q <= 1'b0;
            arm_q     <= 1'b0;
            force_q   <= 1'b0;
            ext_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            armed_q   <= (state_d == ARMED);
            running_q <= (state_d == RUN);
            arm_q     <= bus.ctrl_reg[0];
            force_q   <= bus.ctrl_reg[1];
            ext_q     <= bus.ext_sync_in;
        end
    end

`ifdef PFB_SYNC_CNT_EN
    logic [31:0] sync_count_q;

    // A clear and a pulse in the same cycle leave the count at one.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            sync_count_q <= '0;
        end else if (arm_rise) begin
            sync_count_q <= pulse_d ? 32'd1 : 32'd0;
        end else if (pulse_d) begin
            sync_count_q <= sync_count_q + 32'd1;
        end
    end

    assign bus.sync_count = sync_count_q;
`else
    assign bus.sync_count = 32'h0;
`endif

    assign bus.pfb_sync_out = pulse_q;
    assign bus.armed        = armed_q;
    assign bus.running      = running_q;
endmodule

// File: tb/tb_pfb_sync_arm_gen.sv
// Directed bench for pfb_sync_arm_gen (SYNC_PERIOD=16): expected pulse cycles queued, checked by a monitor.
module tb_pfb_sync_arm_gen;
    localparam int P = 16;

    logic user_clk;
    logic user_rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   exp_q[$];

    pfb_sync_arm_gen_if bus ();

    pfb_sync_arm_gen #(.SYNC_PERIOD(P), .CNT_W(24)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .bus        (bus.slave)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    initial cyc = 0;
    always @(posedge user_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef PFB_SYNC_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Scoreboard: every observed pulse must match the next queued cycle.
    always @(negedge user_clk) begin
        if (user_rst_n && bus.pfb_sync_out) begin
            if (exp_q.size() == 0) chk("unexpected_pulse_cycle", cyc, -1);
            else                   chk("pulse_cycle", cyc, exp_q.pop_front());
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    task automatic q_empty(input string tag);
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        user_rst_n      = 1'b0;
        bus.ctrl_reg    = 32'h0;
        bus.ext_sync_in = 1'b0;
        repeat (2) @(posedge user_clk);
        #1;
        user_rst_n = 1'b1;
        chk("rst_pulse", bus.pfb_sync_out, 0);
        chk("rst_armed", bus.armed, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_count", bus.sync_count, 0);
    endtask

    int t0;

    initial begin
        checks = 0;
        errors = 0;

        // 1: ext pulses while idle produce nothing
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            goto(t0 + 2 + 4 * i);
            bus.ext_sync_in = 1'b1;
            goto(t0 + 4 + 4 * i);
            bus.ext_sync_in = 1'b0;
        end
        goto(t0 + 20);
        chk("s1_armed", bus.armed, 0);
        chk("s1_running", bus.running, 0);
        chk("s1_count", bus.sync_count, 0);
        q_empty("s1_queue");

        // 2: arm on ext source, align to ext rise, free-run; later ext rise ignored
        do_reset();
        t0 = cyc;
        goto(t0 + 5);
        bus.ctrl_reg = 32'h1;
        goto(t0 + 6);
        chk("s2_armed", bus.armed, 1);
        chk("s2_running_pre", bus.running, 0);
        exp_q.push_back(t0 + 21);
        exp_q.push_back(t0 + 37);
        exp_q.push_back(t0 + 53);
        goto(t0 + 20);
        bus.ext_sync_in = 1'b1;
        goto(t0 + 22);
        chk("s2_running", bus.running, 1);
        chk("s2_armed_off", bus.armed, 0);
        bus.ext_sync_in = 1'b0;
        goto(t0 + 30);
        bus.ext_sync_in = 1'b1;
        goto(t0 + 32);
        bus.ext_sync_in = 1'b0;
        goto(t0 + 55);
        chk("s2_count", bus.sync_count, exp_cnt(3));
        q_empty("s2_queue");

        // 3: internal source fires right after arming
        do_reset();
        t0 = cyc;
        exp_q.push_back(t0 + 7);
        exp_q.push_back(t0 + 23);
        exp_q.push_back(t0 + 39);
        goto(t0 + 5);
        bus.ctrl_reg = 32'h5;
        goto(t0 + 6);
        chk("s3_armed", bus.armed, 1);
        goto(t0 + 7);
        chk("s3_running", bus.running, 1);
        goto(t0 + 40);
        chk("s3_count", bus.sync_count, exp_cnt(3));
        q_empty("s3_queue");

        // 4a: force in idle
        do_reset();
        t0 = cyc;
        exp_q.push_back(t0 + 4);
        goto(t0 + 3);
        bus.ctrl_reg = 32'h2;
        goto(t0 + 4);
        chk("s4a_armed", bus.armed, 0);
        chk("s4a_running", bus.running, 0);
        goto(t0 + 8);
        chk("s4a_count", bus.sync_count, exp_cnt(1));
        q_empty("s4a_queue");

        // 4b: force in RUN at counter==5 re-phases the period
        do_reset();
        t0 = cyc;
        exp_q.push_back(t0 + 4);
        exp_q.push_back(t0 + 15);
        exp_q.push_back(t0 + 31);
        exp_q.push_back(t0 + 47);
        goto(t0 + 2);
        bus.ctrl_reg = 32'h5;
        goto(t0 + 14);
        bus.ctrl_reg = 32'h7;
        goto(t0 + 50);
        chk("s4b_running", bus.running, 1);
        chk("s4b_count", bus.sync_count, exp_cnt(4));
        q_empty("s4b_queue");

        // 5: arm+force together in idle -> one pulse, armed
        do_reset();
        t0 = cyc;
        exp_q.push_back(t0 + 4);
        goto(t0 + 3);
        bus.ctrl_reg = 32'h3;
        goto(t0 + 4);
        chk("s5_armed", bus.armed, 1);
        chk("s5_count", bus.sync_count, exp_cnt(1));
        goto(t0 + 12);
        chk("s5_armed_hold", bus.armed, 1);
        q_empty("s5_queue");

        // 5b: software-only source ignores ext; force pulses without leaving ARMED
        do_reset();
        t0 = cyc;
        exp_q.push_back(t0 + 9);
        goto(t0 + 2);
        bus.ctrl_reg = 32'h9;
        goto(t0 + 5);
        bus.ext_sync_in = 1'b1;
        goto(t0 + 6);
        bus.ext_sync_in = 1'b0;
        goto(t0 + 8);
        bus.ctrl_reg = 32'hB;
        goto(t0 + 10);
        chk("s5b_armed", bus.armed, 1);
        chk("s5b_running", bus.running, 0);
        chk("s5b_count", bus.sync_count, exp_cnt(1));
        q_empty("s5b_queue");

        // 6: async reset mid-RUN while a pulse is high, then re-arm from the held arm bit
        do_reset();
        t0 = cyc;
        exp_q.push_back(t0 + 4);
        goto(t0 + 2);
        bus.ctrl_reg = 32'h5;
        goto(t0 + 20);
        chk("s6_pulse_pre", bus.pfb_sync_out, 1);
        exp_q.delete();
        #2;
        user_rst_n = 1'b0;
        #1;
        chk("s6_async_pulse", bus.pfb_sync_out, 0);
        chk("s6_async_running", bus.running, 0);
        chk("s6_async_armed", bus.armed, 0);
        chk("s6_async_count", bus.sync_count, 0);
        goto(t0 + 22);
        user_rst_n = 1'b1;
        exp_q.push_back(t0 + 24);
        goto(t0 + 23);
        chk("s6_rearm", bus.armed, 1);
        goto(t0 + 26);
        chk("s6_running", bus.running, 1);
        q_empty("s6_queue");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
